bit_packer: RTL

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer.sv | 97 +++++++++
 1 files changed

// File: rtl/bit_packer.sv
// Packs variable-length codes (0..32 bits) MSB-first into 32-bit output words.
// A flush pads the trailing partial word with PAD_BIT and drains everything out.
module bit_packer #(
   parameter logic PAD_BIT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] kod_i,
   input  logic [5:0]  uzunluk_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        flush_i,
   output logic [31:0] veri_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        flush_done_o
);

   typedef enum logic [1:0] {RUN, PAD, DRAIN, DONE} state_t;

   localparam logic [63:0] UPPER = 64'hFFFF_FFFF_0000_0000;

   state_t      state, state_next;
   logic [63:0] acc, acc_next;
   logic [6:0]  doluluk, doluluk_next;
   logic [5:0]  len;
   logic [31:0] code;
   logic [63:0] pad_mask;
   logic        accept, emit, pad_fill;

   assign len  = (uzunluk_i > 6'd32) ? 6'd32 : uzunluk_i;
   assign code = (len == 6'd32) ? kod_i : (kod_i & ((32'd1 << len) - 32'd1));

   assign ready_o      = (state == RUN) && (doluluk <= 7'd32);
   assign accept       = valid_i && ready_o;
   assign emit         = (doluluk >= 7'd32) && (!valid_o || ready_i);
   assign flush_done_o = (state == DONE);

   // Ones over acc[63-doluluk:32]: the unfilled part of the head word.
   assign pad_mask = (UPPER >> doluluk) & UPPER;

   // Padding is also allowed in DRAIN so a partial word that only appears
   // after PAD (pending bits were >32 at PAD time) still gets flushed out.
   assign pad_fill = ((state == PAD) || (state == DRAIN)) &&
                     (doluluk != 7'd0) && (doluluk < 7'd32);

   always_comb begin
      acc_next     = acc;
      doluluk_next = doluluk;
      if (emit) begin
         acc_next     = {acc[31:0], 32'd0};
         doluluk_next = doluluk - 7'd32;
      end
      // New code lands right below the bits already held, after any shift.
      if (accept) begin
         acc_next     = acc_next |
                        ({32'd0, code} << (7'd64 - doluluk_next - {1'b0, len}));
         doluluk_next = doluluk_next + {1'b0, len};
      end
      if (pad_fill) begin
         acc_next     = acc | (pad_mask & {64{PAD_BIT}});
         doluluk_next = 7'd32;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (flush_i && !accept) state_next = PAD;
         PAD:     state_next = DRAIN;
         DRAIN:   if ((doluluk == 7'd0) && (!valid_o || ready_i)) state_next = DONE;
         DONE:    state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= RUN;
         acc     <= 64'd0;
         doluluk <= 7'd0;
         veri_o  <= 32'd0;
         valid_o <= 1'b0;
      end else begin
         state   <= state_next;
         acc     <= acc_next;
         doluluk <= doluluk_next;
         if (emit) begin
            veri_o  <= acc[63:32];
            valid_o <= 1'b1;
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule
